vga_sync_to_count: RTL and testbench



---
 rtl/vga_sync_to_count_if.sv | 38 +++
 rtl/vga_sync_to_count.sv | 134 +++++++++++++
 tb/tb_vga_sync_to_count.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_to_count_if.sv
// Sync-input / recovered-timing bundle between a VGA sync source and vga_sync_to_count.
// The master drives the raw syncs. The slave returns the delayed syncs, counts and lock status.
`timescale 1ns/1ps
interface vga_sync_to_count_if;
    logic       i_HSync;
    logic       i_VSync;
    logic       o_HSync;
    logic       o_VSync;
    logic [9:0] o_Col_Count;
    logic [9:0] o_Row_Count;
    logic       o_Display_On;
    logic       o_Locked;
    logic       o_Sync_Err;

    modport master (
        output i_HSync,
        output i_VSync,
        input  o_HSync,
        input  o_VSync,
        input  o_Col_Count,
        input  o_Row_Count,
        input  o_Display_On,
        input  o_Locked,
        input  o_Sync_Err
    );

    modport slave (
        input  i_HSync,
        input  i_VSync,
        output o_HSync,
        output o_VSync,
        output o_Col_Count,
        output o_Row_Count,
        output o_Display_On,
        output o_Locked,
        output o_Sync_Err
    );
endinterface

// File: rtl/vga_sync_to_count.sv
// Recovers VGA column/row counts from an incoming HSync/VSync pair.
// Flywheels through missing pulses and tracks lock over consecutive clean frames.
`timescale 1ns/1ps
module vga_sync_to_count #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    vga_sync_to_count_if.slave      bus
);

    localparam logic [9:0] COL_LAST   = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST   = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] COL_ACTIVE = 10'(ACTIVE_COLS);
    localparam logic [9:0] ROW_ACTIVE = 10'(ACTIVE_ROWS);
    localparam int         GOOD_W     = $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic              p_h;
    logic              p_v;
    logic              hs_q;
    logic              vs_q;
    logic [9:0]        col;
    logic [9:0]        row;
    logic [9:0]        row_next;
    logic              rise_h;
    logic              rise_v;
    logic              h_exp;
    logic              v_exp;
    logic              timing_err;
    logic [1:0]        state;
    logic [GOOD_W-1:0] good_cnt;
    logic              err_q;

    assign rise_h = bus.i_HSync & ~p_h;
    assign rise_v = bus.i_VSync & ~p_v;

    assign h_exp    = (col == COL_LAST);
    assign v_exp    = h_exp && (row == ROW_LAST);
    assign row_next = (row == ROW_LAST) ? 10'd0 : row + 10'd1;

    // A VSync rise at end of frame also stands in for the expected HSync rise there.
    assign timing_err = (rise_v && !v_exp)
                     || (rise_h && !h_exp)
                     || (h_exp && !rise_h && !rise_v)
                     || (v_exp && !rise_v);

    // Edge history resets high so a sync already high at reset release is not an edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            p_h  <= 1'b1;
            p_v  <= 1'b1;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            p_h  <= bus.i_HSync;
            p_v  <= bus.i_VSync;
            hs_q <= bus.i_HSync;
            vs_q <= bus.i_VSync;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (rise_v) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (rise_h || h_exp) begin
            col <= 10'd0;
            row <= row_next;
        end else begin
            col <= col + 10'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    if (rise_v) begin
                        state    <= ST_ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (timing_err) begin
                        good_cnt <= '0;
                        err_q    <= 1'b1;
                    end else if (rise_v) begin
                        good_cnt <= good_cnt + 1'b1;
                        if (good_cnt == GOOD_LAST) begin
                            state <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (timing_err) begin
                        state    <= ST_ACQUIRE;
                        good_cnt <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_SEARCH;
                    good_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.o_HSync      = hs_q;
    assign bus.o_VSync      = vs_q;
    assign bus.o_Col_Count  = col;
    assign bus.o_Row_Count  = row;
    assign bus.o_Locked     = (state == ST_LOCKED);
    assign bus.o_Sync_Err   = err_q;
    assign bus.o_Display_On = (state == ST_LOCKED) && (col < COL_ACTIVE) && (row < ROW_ACTIVE);

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count on a reduced 20x12 raster (16x9 active).
// A generator model produces syncs; the bench checks recovered counts, lock and error pulses.
`timescale 1ns/1ps
module tb_vga_sync_to_count;

    localparam int TC    = 20;
    localparam int TR    = 12;
    localparam int AC    = 16;
    localparam int AR    = 9;
    localparam int LF    = 2;
    localparam int SHORT = 10;

    logic clk;
    logic rst_n;

    int n_total;
    int n_pass;
    int n_fail;

    int gc;
    int gr;
    bit idle;
    bit aligned;
    bit kill_v;
    int sup_h_row;
    int short_row;

    vga_sync_to_count_if bus();

    vga_sync_to_count #(
        .TOTAL_COLS (TC),
        .TOTAL_ROWS (TR),
        .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (gen col %0d row %0d)", tag, obs, exp, gc, gr);
        end
    endtask

    // One pixel clock: drive syncs for the model position, then check the DUT one edge later.
    task automatic tick(input int exp_lock, input int exp_err);
        int   cc;
        int   cr;
        logic hs;
        logic vs;
        logic disp;
        cc = gc;
        cr = gr;
        if (idle) begin
            hs = 1'b0;
            vs = 1'b0;
        end else begin
            hs = (gc < AC);
            vs = (gr < AR);
            if (gr == sup_h_row) hs = 1'b0;
            if (kill_v) vs = 1'b0;
            if (gr == short_row && gc > SHORT - 5) hs = 1'b0;
        end
        bus.i_HSync = hs;
        bus.i_VSync = vs;
        @(posedge clk);
        #1;
        if (aligned) begin
            check("col", 16'(bus.o_Col_Count), 16'(cc));
            check("row", 16'(bus.o_Row_Count), 16'(cr));
            check("hsync_dly", 16'(bus.o_HSync), 16'(hs));
            check("vsync_dly", 16'(bus.o_VSync), 16'(vs));
        end
        if (exp_lock >= 0) begin
            check("locked", 16'(bus.o_Locked), 16'(exp_lock));
            disp = (exp_lock == 1) && (cc < AC) && (cr < AR);
            if (exp_lock == 0 || aligned) check("display_on", 16'(bus.o_Display_On), 16'(disp));
        end
        if (exp_err >= 0) check("sync_err", 16'(bus.o_Sync_Err), 16'(exp_err));
        if (!idle) begin
            if (gr == short_row && gc == SHORT) begin
                gc = 0;
                gr = gr + 1;
            end else if (gc == TC - 1) begin
                gc = 0;
                gr = (gr == TR - 1) ? 0 : gr + 1;
            end else begin
                gc = gc + 1;
            end
        end
    endtask

    task automatic run_to_sof(input int exp_lock, input int exp_err);
        while (!(gc == 0 && gr == 0)) tick(exp_lock, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_col"}, 16'(bus.o_Col_Count), 16'd0);
        check({tag, "_row"}, 16'(bus.o_Row_Count), 16'd0);
        check({tag, "_hsync"}, 16'(bus.o_HSync), 16'd0);
        check({tag, "_vsync"}, 16'(bus.o_VSync), 16'd0);
        check({tag, "_locked"}, 16'(bus.o_Locked), 16'd0);
        check({tag, "_err"}, 16'(bus.o_Sync_Err), 16'd0);
        check({tag, "_disp"}, 16'(bus.o_Display_On), 16'd0);
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        n_fail      = 0;
        gc          = 0;
        gr          = 0;
        idle        = 1'b1;
        aligned     = 1'b0;
        kill_v      = 1'b0;
        sup_h_row   = -1;
        short_row   = -1;
        rst_n       = 1'b0;
        bus.i_HSync = 1'b0;
        bus.i_VSync = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) tick(0, 0);

        // Clean stream: lock one clock after the third frame start, then ten clean frames
        idle    = 1'b0;
        aligned = 1'b1;
        tick(0, 0);
        run_to_sof(0, 0);
        tick(0, 0);
        run_to_sof(0, 0);
        tick(1, 0);
        repeat (7) begin
            run_to_sof(1, 0);
            tick(1, 0);
        end
        run_to_sof(1, 0);
        check("eof_col", 16'(bus.o_Col_Count), 16'(TC - 1));
        check("eof_row", 16'(bus.o_Row_Count), 16'(TR - 1));

        // Missing HSync rise on row 3
        sup_h_row = 3;
        while (gr != 3) tick(1, 0);
        tick(0, 1);
        while (gr == 3) tick(0, 0);
        sup_h_row = -1;
        run_to_sof(0, 0);
        tick(0, 0);
        run_to_sof(0, 0);
        tick(1, 0);
        run_to_sof(1, 0);

        // Missing VSync rise for one whole frame
        kill_v = 1'b1;
        tick(0, 1);
        run_to_sof(0, 0);
        kill_v = 1'b0;
        tick(0, 0);
        run_to_sof(0, 0);
        tick(1, 0);
        run_to_sof(1, 0);

        // Short line: row 5 ends after column SHORT
        short_row = 5;
        while (!(gr == 5 && gc == SHORT)) tick(1, 0);
        tick(1, 0);
        tick(0, 1);
        short_row = -1;
        run_to_sof(0, 0);
        tick(0, 0);
        run_to_sof(0, 0);
        tick(1, 0);

        // Reset mid-frame while locked
        while (gr != 4) tick(1, 0);
        repeat (3) tick(1, 0);
        rst_n   = 1'b0;
        aligned = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) tick(0, 0);
        rst_n = 1'b1;
        run_to_sof(0, 0);
        aligned = 1'b1;
        tick(0, 0);
        run_to_sof(0, 0);
        tick(0, 0);
        run_to_sof(0, 0);
        tick(1, 0);
        run_to_sof(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
